// File: rtl/ad4003_reader_pkg.sv
// Shared constants for the AD4003 SDO reader: FSM encoding, default geometry, lane slicing.
package ad4003_reader_pkg;

  localparam int unsigned N_CH_DEF       = 48;
  localparam int unsigned FRAME_BITS_DEF = 18;
  localparam int unsigned CNT_W_DEF      = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  // Lowest bit of a lane's field inside the flattened sample frame.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/ad4003_lane_shifter.sv
// One SDO lane: MSB-first serial-in shift register, advanced only when shift_en is high.
module ad4003_lane_shifter
  import ad4003_reader_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  adc_read_clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  sdo,
  output logic [FRAME_BITS-1:0] sreg
);

  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (shift_en) begin
      sreg <= {sreg[FRAME_BITS-2:0], sdo};
    end
  end

endmodule

// File: rtl/ad4003_sdo_reader.sv
// Captures N_CH parallel AD4003 SDO lanes per read window, checks the bit count and
// presents one sample frame with valid/ready, plus frame/error/overrun counters.
module ad4003_sdo_reader
  import ad4003_reader_pkg::*;
#(
  parameter int unsigned N_CH       = N_CH_DEF,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                       adc_read_clk,
  input  logic                       rst_n,
  input  logic                       reader_en_sync,
  input  logic [N_CH-1:0]            adc_sdo,
  input  logic                       acq_en,
  input  logic                       cnt_clr,
  output logic [N_CH*FRAME_BITS-1:0] adc_data,
  output logic                       adc_data_valid,
  input  logic                       adc_data_ready,
  output logic [31:0]                frame_cnt,
  output logic [CNT_W-1:0]           frame_err_cnt,
  output logic [CNT_W-1:0]           overrun_cnt,
  output logic                       busy
);

  localparam int unsigned BC_W   = $clog2(FRAME_BITS + 2);
  localparam int unsigned DATA_W = N_CH * FRAME_BITS;

  logic [1:0]        state_q, state_nxt;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_nxt;
  logic              en_d;
  logic              late_q, late_nxt;
  logic              rise_c, fall_c;
  logic              shift_en_c, load_c, err_inc_c, ovr_inc_c;
  logic [DATA_W-1:0] sreg_flat;

  assign rise_c = reader_en_sync && !en_d;
  assign fall_c = !reader_en_sync && en_d;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_lane
    localparam int unsigned LSB = lane_lsb($unsigned(i), FRAME_BITS);
    ad4003_lane_shifter #(.FRAME_BITS(FRAME_BITS)) u_shifter (
      .adc_read_clk (adc_read_clk),
      .rst_n        (rst_n),
      .shift_en     (shift_en_c),
      .sdo          (adc_sdo[i]),
      .sreg         (sreg_flat[LSB +: FRAME_BITS])
    );
  end

  // en_d resets high so a window already open when reset releases never shows a rise.
  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      en_d      <= 1'b1;
      late_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      en_d      <= reader_en_sync;
      late_q    <= late_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    bit_cnt_nxt = bit_cnt_q;
    late_nxt    = late_q;
    shift_en_c  = 1'b0;
    load_c      = 1'b0;
    err_inc_c   = 1'b0;
    ovr_inc_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A window that opened during LATCH is reported when it closes.
        if (fall_c && late_q) begin
          err_inc_c = 1'b1;
          late_nxt  = 1'b0;
        end
        if (rise_c && acq_en) begin
          shift_en_c  = 1'b1;
          bit_cnt_nxt = BC_W'(1);
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (reader_en_sync) begin
          shift_en_c = 1'b1;
          if (bit_cnt_q != BC_W'(FRAME_BITS + 1)) begin
            bit_cnt_nxt = bit_cnt_q + BC_W'(1);
          end
        end else begin
          state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_nxt = ST_IDLE;
        if (rise_c) begin
          late_nxt = 1'b1;
        end
        if (bit_cnt_q != BC_W'(FRAME_BITS)) begin
          err_inc_c = 1'b1;
        end else if (!adc_data_valid || adc_data_ready) begin
          load_c = 1'b1;
        end else begin
          ovr_inc_c = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output frame, handshake and status counters; cnt_clr beats any increment.
  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_data       <= '0;
      adc_data_valid <= 1'b0;
      frame_cnt      <= '0;
      frame_err_cnt  <= '0;
      overrun_cnt    <= '0;
      busy           <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      if (load_c) begin
        adc_data       <= sreg_flat;
        adc_data_valid <= 1'b1;
      end else if (adc_data_valid && adc_data_ready) begin
        adc_data_valid <= 1'b0;
      end
      if (cnt_clr) begin
        frame_cnt <= '0;
      end else if (load_c) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (cnt_clr) begin
        frame_err_cnt <= '0;
      end else if (err_inc_c && (frame_err_cnt != '1)) begin
        frame_err_cnt <= frame_err_cnt + CNT_W'(1);
      end
      if (cnt_clr) begin
        overrun_cnt <= '0;
      end else if (ovr_inc_c && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/ad4003_sdo_reader.md
Name: ad4003_sdo_reader

Overview:
- Downstream of the AD4003 SPI timing generator, in the adc_read_clk domain (80 MHz, phase-delayed for SDO round trip).
- Uses the synchronized read-window strobe reader_en_sync to shift in serial SDO bits from N_CH ADC lanes in parallel.
- At the end of each window it checks the bit count, then presents one parallel sample frame with a valid/ready handshake.
- Also maintains frame, error and overrun counters for the control/status registers.

Parameters:
- N_CH, 48, number of ADC SDO lanes (two 24-lane carrier buses).
- FRAME_BITS, 18, bits per conversion (AD4003 18-bit, MSB first).
- CNT_W, 16, width of the saturating error/overrun counters.

Ports:
- adc_read_clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- reader_en_sync  in  1  read window from the timing generator, already in this domain.
- adc_sdo  in  N_CH  serial data, lane i on bit i, MSB first.
- acq_en  in  1  acquisition enable, sampled only at window start.
- cnt_clr  in  1  synchronous clear of all counters (one-cycle pulse).
- adc_data  out  N_CH*FRAME_BITS  lane i in bits [i*FRAME_BITS +: FRAME_BITS], raw two's complement.
- adc_data_valid  out  1  frame held on adc_data.
- adc_data_ready  in  1  consumer accepts frame when valid&&ready.
- frame_cnt  out  32  good frames accepted into the output register, wraps.
- frame_err_cnt  out  CNT_W  windows with wrong bit count, saturating.
- overrun_cnt  out  CNT_W  good frames dropped because the output was still held, saturating.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all shift registers=0, adc_data=0, adc_data_valid=0, all counters=0, busy=0.
- en_d: reader_en_sync registered once, used for edge detection. rise = en&&!en_d; fall = !en&&en_d.
- adc_sdo is sampled directly on the clock edge, with no extra pipeline stage; alignment is guaranteed by the upstream MMCM delay.
- States:
  - IDLE: on rise && acq_en, shift first bit into every lane, set bit_cnt=1, go to SHIFT. A rise while acq_en=0 is ignored for the whole window.
  - SHIFT: while en=1, per lane sreg <= {sreg[FRAME_BITS-2:0], adc_sdo[i]}; bit_cnt increments, saturating at FRAME_BITS+1. On fall go to LATCH. acq_en falling mid-window does not abort the frame.
  - LATCH (exactly one cycle), then IDLE:
    - bit_cnt != FRAME_BITS: frame_err_cnt++, output untouched.
    - bit_cnt == FRAME_BITS and output free (valid=0, or valid&&ready this cycle): load adc_data from sregs, valid=1, frame_cnt++.
    - bit_cnt == FRAME_BITS and valid=1 && ready=0: new frame dropped, old data kept, overrun_cnt++.
- Latency: adc_data_valid rises 2 cycles after the last en=1 cycle (fall detect, then LATCH register).
- Handshake: valid stays high and adc_data stays stable until valid&&ready. On consumption outside LATCH, valid drops the next cycle. Simultaneous consume and load in LATCH gives valid remaining 1 with the new data.
- Saturating counters hold at all-ones. frame_cnt wraps 0xFFFFFFFF->0.
- cnt_clr has priority over an increment in the same cycle.
- Minimum window spacing: 3 cycles from fall to next rise. A rise seen during LATCH is ignored and counted as a frame error on the following fall.
- rst_n assertion mid-window: everything clears immediately. The rest of that window after release is ignored, because no rise is seen.

Decomposition:
- Package ad4003_reader_pkg holds the state encoding (IDLE/SHIFT/LATCH), default FRAME_BITS/N_CH, and the lane slicing helper constant.
- Sub-module ad4003_lane_shifter is a single-lane FRAME_BITS shift register with a shift enable, instantiated N_CH times by generate. Counting and the FSM stay in the top.

Test Plan:
- Window of exactly 18 cycles; lane0 sends 0x2AAAA, lane47 sends 0x3FFFF, others 0; ready=1 -> valid pulses 1 cycle, 2 cycles after the last bit; data matches; frame_cnt=1.
- Window of 17 cycles, then one of 19 -> no valid, frame_err_cnt=2, adc_data unchanged.
- ready=0; two good frames (0x00001, then 0x00002 on lane0) -> adc_data holds 0x00001, overrun_cnt=1; ready=1 -> valid drops next cycle.
- ready asserted in the LATCH cycle of frame 2 while frame 1 is held -> valid stays 1, data=frame 2, overrun_cnt=0.
- acq_en=0 at rise, then 1 mid-window -> window ignored. acq_en 1->0 mid-window -> frame still delivered.
- rst_n pulsed low at bit 9 of a window -> all outputs 0 immediately; next full window gives correct data with frame_cnt=1. cnt_clr coinciding with an increment -> counter reads 0.
